// File: rtl/elevator_scan_controller.sv
// SCAN-order elevator controller: latches floor calls, travels toward pending
// requests in the current direction, times travel and door dwell, honours SOS/overload.
module elevator_scan_controller #(
  parameter int FLOORS    = 4,
  parameter int FLOOR_W   = 2,
  parameter int MOVE_TIME = 5,
  parameter int DOOR_TIME = 2
) (
  input  logic               i_clk,
  input  logic               i_button_reset_n,
  input  logic [FLOORS-1:0]  i_call,
  input  logic               i_sos_mode,
  input  logic               i_weight_limit_exceeded,
  output logic [FLOORS-1:0]  o_led,
  output logic [FLOORS-1:0]  o_floor_onehot,
  output logic [FLOOR_W-1:0] o_floor_idx,
  output logic               o_door,
  output logic               o_moving,
  output logic               o_dir_up
);

  localparam int CNT_MAX = (MOVE_TIME > DOOR_TIME) ? MOVE_TIME : DOOR_TIME;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  MOVE_LAST = CNT_W'(MOVE_TIME - 1);
  localparam logic [CNT_W-1:0]  DOOR_LAST = CNT_W'(DOOR_TIME - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [FLOORS-1:0] FLOOR0_OH = FLOORS'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DOOR_OPEN = 2'd1,
    S_MOVING    = 2'd2,
    S_HALT      = 2'd3
  } state_t;

  state_t             r_state, w_state;
  logic [FLOORS-1:0]  r_led, w_led;
  logic [FLOORS-1:0]  r_floor_onehot, w_floor_onehot;
  logic [FLOOR_W-1:0] r_floor_idx, w_floor_idx;
  logic               r_dir_up, w_dir_up;
  logic               r_door, w_door;
  logic               r_moving, w_moving;
  logic [CNT_W-1:0]   r_cnt, w_cnt;

  logic [FLOORS-1:0]  w_above_mask, w_below_mask;
  logic               w_ahead_up, w_ahead_down;
  logic               w_here_call;
  logic [FLOORS-1:0]  w_step_onehot;
  logic [FLOOR_W-1:0] w_step_idx;
  logic               w_can_step;

  // Floors strictly above / below the car, and SCAN look-ahead terms
  always_comb begin
    w_above_mask = '0;
    w_below_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (FLOOR_W'(i) > r_floor_idx) begin
        w_above_mask[i] = 1'b1;
      end else begin
        w_above_mask[i] = 1'b0;
      end
      if (FLOOR_W'(i) < r_floor_idx) begin
        w_below_mask[i] = 1'b1;
      end else begin
        w_below_mask[i] = 1'b0;
      end
    end
    w_ahead_up    = |(r_led & w_above_mask);
    w_ahead_down  = |(r_led & w_below_mask);
    w_here_call   = |(i_call & r_floor_onehot);
    w_step_onehot = r_dir_up ? (r_floor_onehot << 1'b1) : (r_floor_onehot >> 1'b1);
    w_step_idx    = r_dir_up ? (r_floor_idx + FLOOR_W'(1)) : (r_floor_idx - FLOOR_W'(1));
    w_can_step    = r_dir_up ? ~r_floor_onehot[FLOORS-1] : ~r_floor_onehot[0];
  end

  // Next-state and next-output logic
  always_comb begin
    w_state        = r_state;
    w_led          = r_led;
    w_floor_onehot = r_floor_onehot;
    w_floor_idx    = r_floor_idx;
    w_dir_up       = r_dir_up;
    w_door         = r_door;
    w_moving       = r_moving;
    w_cnt          = r_cnt;

    if (i_sos_mode) begin
      // Emergency halt drops every request, including one arriving this edge
      w_state  = S_HALT;
      w_led    = '0;
      w_door   = 1'b0;
      w_moving = 1'b0;
      w_cnt    = CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_led    = r_led | (i_call & ~r_floor_onehot);
          w_door   = 1'b0;
          w_moving = 1'b0;
          w_cnt    = CNT_ZERO;
          if (w_here_call || i_weight_limit_exceeded) begin
            w_state = S_DOOR_OPEN;
            w_door  = 1'b1;
          end else if ((r_dir_up && w_ahead_up) || (!r_dir_up && w_ahead_down)) begin
            w_state  = S_MOVING;
            w_moving = 1'b1;
          end else if (w_ahead_up) begin
            w_state  = S_MOVING;
            w_moving = 1'b1;
            w_dir_up = 1'b1;
          end else if (w_ahead_down) begin
            w_state  = S_MOVING;
            w_moving = 1'b1;
            w_dir_up = 1'b0;
          end else begin
            w_state = S_IDLE;
          end
        end

        S_DOOR_OPEN: begin
          w_led    = r_led | (i_call & ~r_floor_onehot);
          w_door   = 1'b1;
          w_moving = 1'b0;
          if (w_here_call || i_weight_limit_exceeded) begin
            w_cnt = CNT_ZERO;
          end else if (r_cnt == DOOR_LAST) begin
            w_state = S_IDLE;
            w_door  = 1'b0;
            w_cnt   = CNT_ZERO;
          end else begin
            w_cnt = r_cnt + CNT_ONE;
          end
        end

        S_MOVING: begin
          w_led    = r_led | i_call;
          w_door   = 1'b0;
          w_moving = 1'b1;
          if (r_cnt == MOVE_LAST) begin
            w_cnt = CNT_ZERO;
            if (w_can_step) begin
              w_floor_idx    = w_step_idx;
              w_floor_onehot = w_step_onehot;
              // Arrival decision uses the registered request, so a same-edge call stays cleared
              if (|(r_led & w_step_onehot)) begin
                w_led    = (r_led | i_call) & ~w_step_onehot;
                w_state  = S_DOOR_OPEN;
                w_door   = 1'b1;
                w_moving = 1'b0;
              end else begin
                w_state = S_MOVING;
              end
            end else begin
              w_state  = S_IDLE;
              w_moving = 1'b0;
            end
          end else begin
            w_cnt = r_cnt + CNT_ONE;
          end
        end

        S_HALT: begin
          w_state  = S_IDLE;
          w_led    = '0;
          w_door   = 1'b0;
          w_moving = 1'b0;
          w_cnt    = CNT_ZERO;
        end

        default: begin
          w_state  = S_IDLE;
          w_led    = '0;
          w_door   = 1'b0;
          w_moving = 1'b0;
          w_cnt    = CNT_ZERO;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_button_reset_n) begin
    if (!i_button_reset_n) begin
      r_state        <= S_IDLE;
      r_led          <= '0;
      r_floor_onehot <= FLOOR0_OH;
      r_floor_idx    <= '0;
      r_dir_up       <= 1'b1;
      r_door         <= 1'b0;
      r_moving       <= 1'b0;
      r_cnt          <= CNT_ZERO;
    end else begin
      r_state        <= w_state;
      r_led          <= w_led;
      r_floor_onehot <= w_floor_onehot;
      r_floor_idx    <= w_floor_idx;
      r_dir_up       <= w_dir_up;
      r_door         <= w_door;
      r_moving       <= w_moving;
      r_cnt          <= w_cnt;
    end
  end

  assign o_led          = r_led;
  assign o_floor_onehot = r_floor_onehot;
  assign o_floor_idx    = r_floor_idx;
  assign o_door         = r_door;
  assign o_moving       = r_moving;
  assign o_dir_up       = r_dir_up;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Random-stimulus bench: a behavioural car model queues the expected indicator
// state for each clock/reset event and a monitor compares the DUT against it.
module tb_elevator_scan_controller;

  localparam int FLOORS    = 4;
  localparam int FLOOR_W   = 2;
  localparam int MOVE_TIME = 5;
  localparam int DOOR_TIME = 3;
  localparam int NCYC      = 6000;

  localparam int M_IDLE = 0;
  localparam int M_DOOR = 1;
  localparam int M_MOVE = 2;
  localparam int M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [FLOORS-1:0]  call;
  logic               sos;
  logic               wle;
  logic [FLOORS-1:0]  led;
  logic [FLOORS-1:0]  floor_onehot;
  logic [FLOOR_W-1:0] floor_idx;
  logic               door;
  logic               moving;
  logic               dir_up;

  elevator_scan_controller #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .MOVE_TIME(MOVE_TIME), .DOOR_TIME(DOOR_TIME)
  ) dut (
    .i_clk                   (clk),
    .i_button_reset_n        (rst_n),
    .i_call                  (call),
    .i_sos_mode              (sos),
    .i_weight_limit_exceeded (wle),
    .o_led                   (led),
    .o_floor_onehot          (floor_onehot),
    .o_floor_idx             (floor_idx),
    .o_door                  (door),
    .o_moving                (moving),
    .o_dir_up                (dir_up)
  );

  typedef struct packed {
    logic [FLOORS-1:0]  led;
    logic [FLOORS-1:0]  oh;
    logic [FLOOR_W-1:0] idx;
    logic               door;
    logic               moving;
    logic               dir_up;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   mon_en = 1'b0;

  // Behavioural car: mode, pending floors, position, direction, timer
  int m_mode;
  bit m_pend[FLOORS];
  int m_floor;
  bit m_up;
  int m_timer;
  bit m_door;
  bit m_moving;

  function automatic obs_t m_snapshot();
    obs_t o;
    o = '0;
    for (int k = 0; k < FLOORS; k++) o.led[k] = m_pend[k];
    o.oh[m_floor] = 1'b1;
    o.idx    = FLOOR_W'(m_floor);
    o.door   = m_door;
    o.moving = m_moving;
    o.dir_up = m_up;
    return o;
  endfunction

  function automatic bit any_in(input bit v[FLOORS], input int lo, input int hi);
    bit r;
    r = 1'b0;
    for (int k = 0; k < FLOORS; k++) if (k >= lo && k <= hi && v[k]) r = 1'b1;
    return r;
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE;
    for (int k = 0; k < FLOORS; k++) m_pend[k] = 1'b0;
    m_floor  = 0;
    m_up     = 1'b1;
    m_timer  = 0;
    m_door   = 1'b0;
    m_moving = 1'b0;
  endtask

  task automatic start_travel(input bit up);
    m_up     = up;
    m_mode   = M_MOVE;
    m_moving = 1'b1;
    m_timer  = 0;
  endtask

  task automatic m_step(input logic [FLOORS-1:0] c, input bit s, input bit w);
    bit old[FLOORS];
    bit here;
    bit up_req;
    bit dn_req;
    old  = m_pend;
    here = c[m_floor];
    if (s) begin
      for (int k = 0; k < FLOORS; k++) m_pend[k] = 1'b0;
      m_mode = M_HALT; m_door = 1'b0; m_moving = 1'b0; m_timer = 0;
      return;
    end
    case (m_mode)
      M_HALT: begin
        m_mode = M_IDLE; m_timer = 0;
      end
      M_IDLE: begin
        for (int k = 0; k < FLOORS; k++) if (c[k] && k != m_floor) m_pend[k] = 1'b1;
        up_req = any_in(old, m_floor + 1, FLOORS - 1);
        dn_req = any_in(old, 0, m_floor - 1);
        if (here || w) begin
          m_mode = M_DOOR; m_door = 1'b1; m_timer = 0;
        end else if (m_up ? up_req : dn_req) start_travel(m_up);
        else if (up_req) start_travel(1'b1);
        else if (dn_req) start_travel(1'b0);
      end
      M_DOOR: begin
        for (int k = 0; k < FLOORS; k++) if (c[k] && k != m_floor) m_pend[k] = 1'b1;
        if (here || w) m_timer = 0;
        else if (m_timer == DOOR_TIME - 1) begin
          m_mode = M_IDLE; m_door = 1'b0; m_timer = 0;
        end else m_timer++;
      end
      default: begin
        for (int k = 0; k < FLOORS; k++) if (c[k]) m_pend[k] = 1'b1;
        if (m_timer == MOVE_TIME - 1) begin
          m_timer = 0;
          m_floor = m_up ? m_floor + 1 : m_floor - 1;
          if (old[m_floor]) begin
            m_pend[m_floor] = 1'b0;
            m_mode = M_DOOR; m_door = 1'b1; m_moving = 1'b0;
          end
        end else m_timer++;
      end
    endcase
  endtask

  // Monitor: every clock edge or reset assertion yields one expected observation
  initial begin
    obs_t e;
    obs_t a;
    wait (mon_en);
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      a = '{led: led, oh: floor_onehot, idx: floor_idx, door: door, moving: moving, dir_up: dir_up};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty t=%0t: DUT presented led=%b idx=%0d with nothing expected",
                 $time, a.led, a.idx);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_err++;
          $display("FAIL state t=%0t: got led=%b oh=%b idx=%0d door=%b mov=%b up=%b, want led=%b oh=%b idx=%0d door=%b mov=%b up=%b",
                   $time, a.led, a.oh, a.idx, a.door, a.moving, a.dir_up,
                   e.led, e.oh, e.idx, e.door, e.moving, e.dir_up);
        end
      end
    end
  end

  // Stimulus: random calls, held SOS/overload episodes and occasional async resets
  initial begin
    int hold;
    rst_n = 1'b0;
    call  = '0;
    sos   = 1'b0;
    wle   = 1'b0;
    hold  = 0;
    m_reset();
    repeat (2) @(negedge clk);
    exp_q.push_back(m_snapshot());
    mon_en = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (rst_n == 1'b0) begin
        if (hold == 0) rst_n = 1'b1;
        else hold--;
      end else if (cyc > 50 && $urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        hold  = 1;
        m_reset();
        exp_q.push_back(m_snapshot());
      end

      if (sos) sos = ($urandom_range(0, 7) != 0);
      else     sos = ($urandom_range(0, 299) == 0);
      if (wle) wle = ($urandom_range(0, 5) != 0);
      else     wle = ($urandom_range(0, 79) == 0);

      call = '0;
      if ($urandom_range(0, 9) == 0) call[$urandom_range(0, FLOORS - 1)] = 1'b1;
      if ($urandom_range(0, 29) == 0) call[$urandom_range(0, FLOORS - 1)] = 1'b1;
      if ($urandom_range(0, 39) == 0) call[m_floor] = 1'b1;

      if (rst_n == 1'b0) m_reset();
      else m_step(call, sos, wle);
      exp_q.push_back(m_snapshot());
    end

    @(negedge clk);
    call = '0;
    sos  = 1'b0;
    wle  = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected observations never consumed, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/elevator_scan_controller.md
# elevator_scan_controller

Parametrised elevator controller for an N-floor car. It latches hall/cabin calls into a pending-request vector and serves them in SCAN order, continuing in the current direction while requests remain ahead. It times floor-to-floor travel and door dwell with internal cycle counters. It sits between the button/LED front end and the floor/door indicators, and applies the SOS and weight-limit overrides.

## Interface
- FLOORS, 4: number of floors, 2..16; floor 0 is the bottom.
- FLOOR_W, 2: width of floor index, ≥ clog2(FLOORS).
- MOVE_TIME, 5: clk cycles to travel one floor, ≥1.
- DOOR_TIME, 2: clk cycles door stays open, ≥1.
- clk  in  1  system clock, all state on rising edge.
- button_reset_n  in  1  asynchronous active-low reset.
- call  in  FLOORS  request per floor; any cycle high registers a request.
- sos_mode  in  1  emergency halt, level-sensitive.
- weight_limit_exceeded  in  1  overload, level-sensitive.
- led  out  FLOORS  pending-request vector.
- floor_onehot  out  FLOORS  current floor, one-hot.
- floor_idx  out  FLOOR_W  current floor, binary.
- door  out  1  door open.
- moving  out  1  car travelling.
- dir_up  out  1  current/last scan direction, 1 = up.

## Operation
- States: IDLE, DOOR_OPEN, MOVING, HALT. All outputs are registered.
- Reset values: state IDLE, floor_idx 0, floor_onehot = 1, dir_up 1, led 0, door 0, moving 0, counter 0.
- Priority each cycle, highest first: reset, sos_mode, weight_limit_exceeded, normal operation.
- Request latch: call[i] sets led[i]. Exception: if i is the current floor and state is IDLE or DOOR_OPEN, the bit is not set; the door instead opens or restarts its timer.
- Direction terms: ahead_up = |led above floor_idx; ahead_down = |led below floor_idx.
- IDLE:
  - Current-floor call or weight_limit_exceeded → DOOR_OPEN.
  - Else, if dir_up & ahead_up, or ~dir_up & ahead_down → MOVING, keep dir_up.
  - Else if ahead_up → MOVING, dir_up = 1.
  - Else if ahead_down → MOVING, dir_up = 0.
  - Else stay in IDLE.
- MOVING:
  - moving = 1, door = 0; counter counts 0..MOVE_TIME-1.
  - At terminal count: floor_idx ±1 per dir_up and counter clears.
  - If led[new floor] is set: clear it on the same edge → DOOR_OPEN.
  - Else stay in MOVING. A request ahead always exists, so the car never leaves floor 0 downward or floor FLOORS-1 upward.
  - weight_limit_exceeded has no effect while MOVING.
- DOOR_OPEN:
  - door = 1, moving = 0; counter counts 0..DOOR_TIME-1.
  - weight_limit_exceeded or a current-floor call holds the counter at 0.
  - At terminal count → IDLE.
- HALT (any state while sos_mode = 1):
  - moving = 0, door = 0; led is cleared and calls are ignored.
  - A partial travel count is discarded; floor_idx keeps the last floor reached.
  - When sos_mode falls → IDLE with counter 0.
- Reset mid-operation returns all outputs to their reset values immediately, with no wait for clk.

## Timing
- call[i] high at edge t → led[i] = 1 after edge t.
- IDLE decision at edge t → moving = 1 after edge t.
- floor_idx changes exactly MOVE_TIME cycles after MOVING is entered, and every MOVE_TIME cycles thereafter.
- Arrival edge: floor_idx update, led bit clear, door = 1 and moving = 0 all occur on the same edge.
- Door dwell is exactly DOOR_TIME cycles absent hold conditions, followed by at least one IDLE cycle before departure.
- sos_mode high at edge t → HALT after edge t.
- Same-cycle collisions: a call that coincides with the clearing of the same bit leaves the bit cleared. A call arriving on the same edge sos_mode rises is dropped.

## Test plan
Settings: FLOORS=4, MOVE_TIME=5, DOOR_TIME=3.
- Reset, then call=4'b1000 for 1 cycle → led=1000; moving=1. floor_idx steps 1, 2, 3 at 5-cycle intervals; at floor 3, led=0, door=1 for 3 cycles, then IDLE.
- Car at floor 1 travelling up, with led=0101 set while moving to floor 2 → serves floor 2 then floor 0 with dir_up=0. It never revisits floor 3.
- Request for the current floor while in IDLE → door=1 for 3 cycles; led stays 0.
- weight_limit_exceeded held 10 cycles during DOOR_OPEN → door stays 1 for 10 cycles; closes 3 cycles after release.
- sos_mode raised 2 cycles into travel 0→1 → moving=0, led=0, floor_idx=0. After release: IDLE, door=0.
- button_reset_n pulsed low mid-travel at floor 2 → floor_idx=0, led=0, dir_up=1 asynchronously.
